// File: rtl/ahb_sink_sram_slave.sv
// AHB-Lite word SRAM slave for the sink side of the AHB-AHB bridge.
// Legal transfers take WAIT_STATES+1 data-phase cycles, errors take two; sleep req/ack handshake.
module ahb_sink_sram_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 64,
  parameter int                    WAIT_STATES = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_hselx,
  input  logic                  i_htrans,
  input  logic [2:0]            i_hsize,
  input  logic                  i_hwrite,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata,
  input  logic                  i_sleep_req,
  output logic                  o_sleep_ack
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = 3;
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2, S_SLEEP
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  asleep, asleep_nxt;

  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic [LANES-1:0]      lanes_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  can_accept;
  logic                  accept;
  logic                  aligned;
  logic                  in_range;
  logic                  legal;
  logic [ADDR_WIDTH-1:0] offset;
  logic [LANES-1:0]      lanes;

  assign can_accept = (state == S_IDLE) || (state == S_DONE) ||
                      (state == S_ERR2) || (state == S_SLEEP);
  assign accept     = can_accept & i_hselx & i_htrans & i_hready;
  assign offset     = i_haddr - BASE_ADDR;
  assign in_range   = (i_haddr >= BASE_ADDR) && ((offset >> 2) < ADDR_WIDTH'(MEM_DEPTH));
  assign legal      = aligned & in_range;

  always_comb begin
    aligned = 1'b0;
    lanes   = '1;
    case (i_hsize)
      3'd0: begin
        aligned = 1'b1;
        lanes   = LANES'(1) << i_haddr[1:0];
      end
      3'd1: begin
        aligned = ~i_haddr[0];
        lanes   = i_haddr[1] ? LANES'(4'b1100) : LANES'(4'b0011);
      end
      3'd2: aligned = (i_haddr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      asleep <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      asleep <= asleep_nxt;
    end
  end

  // Next state: accepting states prioritise a new transfer over sleep entry,
  // and anything accepted while asleep is answered with ERROR.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    asleep_nxt = asleep;
    case (state)
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_ERR1: state_nxt = S_ERR2;
      S_IDLE, S_DONE, S_ERR2, S_SLEEP: begin
        if (accept) begin
          if (!legal || asleep) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_W'(WAIT_STATES - 1);
          end
        end else if (i_sleep_req) begin
          state_nxt  = S_SLEEP;
          asleep_nxt = 1'b1;
        end else begin
          state_nxt  = S_IDLE;
          asleep_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_hreadyout = 1'b1;
    o_hresp     = 1'b0;
    o_hrdata    = '0;
    case (state)
      S_WAIT: o_hreadyout = 1'b0;
      S_ERR1: begin
        o_hreadyout = 1'b0;
        o_hresp     = 1'b1;
      end
      S_ERR2: o_hresp = 1'b1;
      S_DONE: if (!write_q) o_hrdata = mem[idx_q];
      default: ;
    endcase
  end

  assign o_sleep_ack = asleep;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q   <= '0;
      write_q <= 1'b0;
      lanes_q <= '0;
    end else if (accept) begin
      idx_q   <= offset[IDX_W+1:2];
      write_q <= i_hwrite;
      lanes_q <= lanes;
    end
  end

  // Write data is only valid in the data phase, so commit on the DONE edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (state == S_DONE && write_q) begin
      for (int b = 0; b < LANES; b++) begin
        if (lanes_q[b]) mem[idx_q][8*b +: 8] <= i_hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sink_sram_slave.sv
// Two slaves (WAIT_STATES=1 and 0) behind a shared AHB bus; a byte-array model
// predicts each response and a negedge monitor checks every data-phase cycle.
module tb_ahb_sink_sram_slave;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } tr_t;

  typedef struct {
    bit          err;
    bit          chk_rd;
    logic [31:0] rdata;
    int          nwait;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel, htrans, hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata;
  logic        sel;            // 0: WAIT_STATES=1 slave, 1: WAIT_STATES=0 slave
  logic        sleep_req1, sleep_req0;
  logic        rdy1, resp1, ack1, rdy0, resp0, ack0;
  logic [31:0] rd1, rd0;
  logic        bus_hready, bus_hresp;
  logic [31:0] bus_hrdata;
  logic        hsel1, hsel0;

  int   checks = 0;
  int   errors = 0;
  bit   model_asleep;
  logic [7:0] mb [2][256];
  exp_t expq[$];
  tr_t  pend[$];

  always #5 clk = ~clk;

  assign hsel1      = hsel & ~sel;
  assign hsel0      = hsel & sel;
  assign bus_hready = sel ? rdy0  : rdy1;
  assign bus_hresp  = sel ? resp0 : resp1;
  assign bus_hrdata = sel ? rd0   : rd1;

  ahb_sink_sram_slave #(.WAIT_STATES(1)) u_ws1 (
    .i_clk(clk), .i_rst(rst), .i_hselx(hsel1), .i_htrans(htrans), .i_hsize(hsize),
    .i_hwrite(hwrite), .i_haddr(haddr), .i_hwdata(hwdata), .i_hready(bus_hready),
    .o_hreadyout(rdy1), .o_hresp(resp1), .o_hrdata(rd1),
    .i_sleep_req(sleep_req1), .o_sleep_ack(ack1));

  ahb_sink_sram_slave #(.WAIT_STATES(0)) u_ws0 (
    .i_clk(clk), .i_rst(rst), .i_hselx(hsel0), .i_htrans(htrans), .i_hsize(hsize),
    .i_hwrite(hwrite), .i_haddr(haddr), .i_hwdata(hwdata), .i_hready(bus_hready),
    .o_hreadyout(rdy0), .o_hresp(resp0), .o_hrdata(rd0),
    .i_sleep_req(sleep_req0), .o_sleep_ack(ack0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b0;
    if ((a % (32'd1 << s)) != 0) return 1'b0;
    return a < 32'd256;
  endfunction

  // Presents an address phase and records what the slave must answer.
  task automatic drive_addr(input tr_t t);
    exp_t e;
    int   s, wi, a;
    hsel = 1'b1; htrans = 1'b1;
    haddr = t.addr; hwrite = t.write; hsize = t.size;
    s = sel ? 1 : 0;
    e.nwait  = sel ? 0 : 1;
    e.err    = model_asleep || !is_legal(t.addr, t.size);
    e.chk_rd = 1'b0;
    e.rdata  = '0;
    if (!e.err) begin
      if (t.write) begin
        for (int k = 0; k < (1 << t.size); k++) begin
          a = int'(t.addr) + k;
          mb[s][a] = t.wdata[8*(a % 4) +: 8];
        end
      end else begin
        wi = (int'(t.addr) / 4) * 4;
        e.chk_rd = 1'b1;
        e.rdata  = {mb[s][wi+3], mb[s][wi+2], mb[s][wi+1], mb[s][wi]};
      end
    end
    expq.push_back(e);
  endtask

  // Returns just after the first rising edge at which bus HREADY was high.
  task automatic wait_hready();
    bit r;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      r = bus_hready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 32);
    if (!r) chk("hready_timeout", 32'(r), 32'd1);
  endtask

  task automatic add(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
    tr_t t;
    t.addr = a; t.write = w; t.size = s; t.wdata = d;
    pend.push_back(t);
  endtask

  // Issues queued transfers back-to-back with AHB address/data pipelining.
  task automatic run_pending();
    tr_t         t;
    logic [31:0] prev_wd;
    prev_wd = '0;
    while (pend.size() > 0) begin
      t = pend.pop_front();
      hwdata = prev_wd;
      drive_addr(t);
      wait_hready();
      prev_wd = t.wdata;
    end
    hsel = 1'b0; htrans = 1'b0;
    hwdata = prev_wd;
    wait_hready();
  endtask

  // Monitor: checks every data-phase cycle against the popped expectation.
  initial begin
    bit   act;
    int   k;
    bit   rdy_exp;
    exp_t e;
    act = 1'b0;
    k   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 1'b0;
        continue;
      end
      if (act) begin
        rdy_exp = e.err ? (k == 1) : (k == e.nwait);
        chk(e.err ? "err_hresp" : "ok_hresp", 32'(bus_hresp), 32'(e.err));
        chk("hreadyout", 32'(bus_hreadyout_now()), 32'(rdy_exp));
        if (rdy_exp && e.chk_rd)             chk("rdata", bus_hrdata, e.rdata);
        else if (!(rdy_exp && !e.err))       chk("rdata_zero", bus_hrdata, 32'd0);
        k++;
        if (rdy_exp || bus_hready) act = 1'b0;
      end
      if (hsel && htrans && bus_hready) begin
        if (expq.size() == 0) begin
          chk("unexpected_accept", 32'd1, 32'd0);
        end else begin
          e   = expq.pop_front();
          act = 1'b1;
          k   = 0;
        end
      end
    end
  end

  function automatic logic bus_hreadyout_now();
    return bus_hready;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  s;
    int          n;
    hsel = 1'b0; htrans = 1'b0; hwrite = 1'b0; hsize = '0;
    haddr = '0; hwdata = '0; sel = 1'b0;
    sleep_req1 = 1'b0; sleep_req0 = 1'b0; model_asleep = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++) mb[i][j] = 8'h00;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hreadyout", 32'(rdy1), 32'd1);
    chk("rst_hresp",     32'(resp1), 32'd0);
    chk("rst_hrdata",    rd1, 32'd0);
    chk("rst_sleep_ack", 32'(ack1), 32'd0);
    chk("rst_hreadyout_ws0", 32'(rdy0), 32'd1);
    @(posedge clk); #1;

    add(32'h0, 1'b0, 3'd2, 32'h0);
    run_pending();

    add(32'h8, 1'b1, 3'd2, 32'hDEADBEEF);
    add(32'h8, 1'b0, 3'd2, 32'h0);
    run_pending();

    add(32'h8, 1'b1, 3'd2, 32'h11223344);
    add(32'h9, 1'b1, 3'd0, 32'h0000AA00);
    add(32'h8, 1'b0, 3'd2, 32'h0);
    add(32'hA, 1'b1, 3'd1, 32'h55660000);
    add(32'h8, 1'b0, 3'd2, 32'h0);
    run_pending();

    add(32'h100, 1'b1, 3'd2, 32'hFFFFFFFF);
    add(32'h2,   1'b1, 3'd2, 32'hFFFFFFFF);
    add(32'h0,   1'b1, 3'd3, 32'hFFFFFFFF);
    add(32'h0,   1'b0, 3'd2, 32'h0);
    add(32'h8,   1'b0, 3'd2, 32'h0);
    run_pending();

    // Address phases without select or without NONSEQ must not start a transfer.
    hsel = 1'b0; htrans = 1'b1; haddr = 32'h8; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 1'b0;
    @(negedge clk);
    chk("nosel_hreadyout", 32'(rdy1), 32'd1);
    chk("nosel_hresp",     32'(resp1), 32'd0);
    @(posedge clk); #1;
    hsel = 1'b0;
    @(negedge clk);
    chk("idle_hreadyout", 32'(rdy1), 32'd1);
    chk("idle_hresp",     32'(resp1), 32'd0);
    @(posedge clk); #1;

    sel = 1'b1;
    add(32'h4, 1'b1, 3'd2, 32'hCAFE0001);
    add(32'h4, 1'b0, 3'd2, 32'h0);
    run_pending();
    sel = 1'b0;

    // Sleep request raised mid-transfer: ack only after that transfer's DONE.
    begin
      tr_t t;
      t.addr = 32'h10; t.write = 1'b1; t.size = 3'd2; t.wdata = 32'h600DF00D;
      hwdata = '0;
      drive_addr(t);
      wait_hready();
      hsel = 1'b0; htrans = 1'b0; hwdata = t.wdata; sleep_req1 = 1'b1;
      @(negedge clk); chk("ack_in_wait",  32'(ack1), 32'd0);
      @(negedge clk); chk("ack_in_done",  32'(ack1), 32'd0);
      @(negedge clk); chk("ack_in_sleep", 32'(ack1), 32'd1);
      @(posedge clk); #1;
    end
    model_asleep = 1'b1;
    add(32'h10, 1'b1, 3'd2, 32'h0BADF00D);
    add(32'h10, 1'b0, 3'd2, 32'h0);
    run_pending();
    @(negedge clk); chk("ack_after_err", 32'(ack1), 32'd1);
    @(posedge clk); #1;
    sleep_req1 = 1'b0;
    @(negedge clk); chk("ack_hold",    32'(ack1), 32'd1);
    @(negedge clk); chk("ack_release", 32'(ack1), 32'd0);
    @(posedge clk); #1;
    model_asleep = 1'b0;
    add(32'h10, 1'b0, 3'd2, 32'h0);
    run_pending();

    for (int it = 0; it < 60; it++) begin
      sel = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        s = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 9) < 8) a = a & ~((32'd1 << s) - 32'd1);
        if ($urandom_range(0, 9) == 0) a = a + 32'h100;
        add(a, 1'($urandom_range(0, 1)), s, $urandom);
      end
      run_pending();
    end

    repeat (4) @(posedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
